// File: rtl/multibyte_add_seq.sv
// Purpose : byte-serial multi-byte adder/subtractor sharing one 8-bit ripple-carry adder.
// Latency : Start accepted at edge T, bytes processed on edges T+1..T+NBYTES, Done in cycle T+NBYTES+1.
// Backpr. : none; Start is ignored while Busy, accepted in IDLE or in the Done cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   Start, OpA, OpB     request + operands (operands sampled only on the accept edge)
//   Cin, Sub            carry-in to byte 0, subtract select (sampled on the accept edge)
//   Busy, Done          operation in progress, one-cycle completion pulse
//   Result, Cout        sum (mod 2^(8*NBYTES)) and carry out of the MSB byte
//   Overflow            signed overflow of the final result
//
// Build option: define MULTIBYTE_ADD_SEQ_SUB_EN to compile in subtraction
// (A + ~B + 1, Cout = 1 meaning no borrow). Without it, Sub is ignored.

module add8_rca (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [8:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[8];
    end
endmodule

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start,
    input  logic [8*NBYTES-1:0]   OpA,
    input  logic [8*NBYTES-1:0]   OpB,
    input  logic                  Cin,
    input  logic                  Sub,
    output logic                  Busy,
    output logic                  Done,
    output logic [8*NBYTES-1:0]   Result,
    output logic                  Cout,
    output logic                  Overflow
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, b_q, result_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, cout_q, ovf_q;

    logic               accept, last;
    logic [W-1:0]       b_in;
    logic               c_in;
    logic [7:0]         a_byte, b_byte, sum_byte;
    logic               sum_co;

    // Operand conditioning happens once, at accept, so RUN sees a plain add.
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    assign b_in = Sub ? ~OpB : OpB;
    assign c_in = Sub ? 1'b1 : Cin;
`else
    logic unused_sub;
    assign unused_sub = Sub;
    assign b_in       = OpB;
    assign c_in       = Cin;
`endif

    assign accept = Start && (state_q != RUN);
    assign last   = (idx_q == IDX_W'(NBYTES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = Start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign a_byte = a_q[{idx_q, 3'b000} +: 8];
    assign b_byte = b_q[{idx_q, 3'b000} +: 8];

    add8_rca u_add8 (
        .a  (a_byte),
        .b  (b_byte),
        .ci (carry_q),
        .s  (sum_byte),
        .co (sum_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_q     <= OpA;
            b_q     <= b_in;
            carry_q <= c_in;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            result_q[{idx_q, 3'b000} +: 8] <= sum_byte;
            carry_q <= sum_co;
            idx_q   <= idx_q + IDX_W'(1);
            if (last) begin
                cout_q <= sum_co;
                // Signed overflow: operands agree in sign, result does not.
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (sum_byte[7] != a_q[W-1]);
            end
        end
    end

    assign Busy     = (state_q == RUN);
    assign Done     = (state_q == DONE);
    assign Result   = result_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;
endmodule

// File: tb/tb_multibyte_add_seq.sv
module tb_multibyte_add_seq;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Start = 1'b0;
    logic [31:0]   OpA = '0, OpB = '0;
    logic          Cin = 1'b0, Sub = 1'b0;
    logic          Busy, Done, Cout, Overflow;
    logic [31:0]   Result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (Start),
        .OpA      (OpA),
        .OpB      (OpB),
        .Cin      (Cin),
        .Sub      (Sub),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive a request, let it be taken on the next edge, then scramble the
    // operand inputs so any late sampling shows up in the result.
    task automatic accept_op(input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic sb);
        Start = 1'b1; OpA = a; OpB = b; Cin = ci; Sub = sb;
        @(posedge clk); #1;
        Start = 1'b0; OpA = ~a; OpB = a ^ b; Cin = ~ci; Sub = ~sb;
    endtask

    // Count edges after the accept edge until Done is seen; -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (Done) begin n = i; break; end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb, input logic [31:0] er,
                          input logic ec, input logic eo);
        int n;
        accept_op(a, b, ci, sb);
        chk({tag, ".busy"}, 64'(Busy), 64'd1);
        wait_done(n);
        // Done lands in cycle T+NBYTES+1, i.e. NBYTES edges after accept.
        chk({tag, ".lat"}, 64'(n), 64'(NB));
        chk({tag, ".res"}, 64'(Result), 64'(er));
        chk({tag, ".cout"}, 64'(Cout), 64'(ec));
        chk({tag, ".ovf"}, 64'(Overflow), 64'(eo));
        chk({tag, ".busy_done"}, 64'(Busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 64'(Done), 64'd0);
        chk({tag, ".hold"}, 64'({Cout, Overflow, Result}), 64'({ec, eo, er}));
    endtask

    initial begin
        int n;
        int dones;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(Busy), 64'd0);
        chk("rst.done", 64'(Done), 64'd0);
        chk("rst.res", 64'(Result), 64'd0);
        chk("rst.cout", 64'(Cout), 64'd0);
        chk("rst.ovf", 64'(Overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed add vectors
        run_op("ff_p1",    32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("posovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("cin",      32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        run_op("negovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // Subtract select (Cin set to 1 under subtract to show it is ignored there)
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
        run_op("sub5m7",   32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub7m5",   32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        run_op("subcin",   32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`else
        run_op("sub5m7",   32'd5, 32'd7, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
        run_op("sub7m5",   32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
`endif

        // Start pulsed during RUN is ignored
        accept_op(32'd1, 32'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        Start = 1'b1; OpA = 32'hAAAA_AAAA; OpB = 32'h5555_5555;
        @(posedge clk); #1;
        Start = 1'b0;
        dones = 0;
        n = -1;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk); #1;
            if (Done && n < 0) n = i;
            if (Done) dones++;
        end
        chk("ignrun.lat", 64'(n), 64'(NB));
        chk("ignrun.res", 64'(Result), 64'd3);
        chk("ignrun.ndone", 64'(dones), 64'd1);
        chk("ignrun.idle", 64'(Busy), 64'd0);

        // Start held through DONE: back-to-back, no IDLE cycle
        accept_op(32'd10, 32'd20, 1'b0, 1'b0);
        Start = 1'b1; OpA = 32'h0102_0304; OpB = 32'h1020_3040; Cin = 1'b0; Sub = 1'b0;
        wait_done(n);
        chk("b2b.lat1", 64'(n), 64'(NB));
        chk("b2b.res1", 64'(Result), 64'd30);
        @(posedge clk); #1;
        Start = 1'b0; OpA = '0; OpB = '0;
        chk("b2b.busy", 64'(Busy), 64'd1);
        chk("b2b.nodone", 64'(Done), 64'd0);
        wait_done(n);
        chk("b2b.lat2", 64'(n), 64'(NB));
        chk("b2b.res2", 64'(Result), 64'h1122_3344);
        @(posedge clk); #1;

        // Reset during the byte-2 RUN cycle (previous Cout set to show it clears)
        run_op("pre_rst", 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        accept_op(32'hFFFF_FFFF, 32'h0101_0101, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.busy_pre", 64'(Busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.busy", 64'(Busy), 64'd0);
        chk("mid.res", 64'(Result), 64'd0);
        chk("mid.cout", 64'(Cout), 64'd0);
        chk("mid.done", 64'(Done), 64'd0);
        dones = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        // No Start: the aborted operation must never complete
        repeat (6) begin
            @(posedge clk); #1;
            if (Done || Busy) dones++;
        end
        chk("mid.nodone", 64'(dones), 64'd0);
        run_op("post_rst", 32'h0000_0FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0);

        // Accept on the very first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        Start = 1'b1; OpA = 32'h0000_0003; OpB = 32'h0000_0004; Cin = 1'b0; Sub = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("first.busy", 64'(Busy), 64'd1);
        wait_done(n);
        chk("first.lat", 64'(n), 64'(NB));
        chk("first.res", 64'(Result), 64'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 SHALL have parameter: NBYTES, 4, operand width in bytes (legal 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: Start  input  1  request a new operation; sampled only while accepting (REQ-011).
REQ-005 SHALL have port: OpA  input  8*NBYTES  operand A; must be valid in the Start cycle only.
REQ-006 SHALL have port: OpB  input  8*NBYTES  operand B; must be valid in the Start cycle only.
REQ-007 SHALL have port: Cin  input  1  carry-in to byte 0.
REQ-008 SHALL have port: Sub  input  1  subtract select, honoured only per REQ-028/REQ-029.
REQ-009 SHALL have port: Busy  output  1  high while an operation is in progress.
REQ-010 SHALL have ports: Done  output  1  one-cycle completion pulse; Result  output  8*NBYTES  sum; Cout  output  1  carry out of MSB byte; Overflow  output  1  signed overflow.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; Start is accepted in IDLE or DONE, and ignored in RUN.
REQ-012 SHALL, on acceptance, latch OpA, OpB, initial carry, byte index = 0; next state RUN; Busy = 1 from the next cycle.
REQ-013 SHALL, in each RUN cycle, add byte[idx] of A and B plus the carry register through one instance of the codebase's 8-bit ripple-carry adder, write Result byte[idx], and update the carry register from the adder carry-out.
REQ-014 SHALL process bytes LSB first; after byte NBYTES-1 it transitions RUN -> DONE.
REQ-015 SHALL, in DONE, hold Done = 1 and Busy = 0 for exactly one cycle, then go to IDLE unless Start is high (back-to-back accept -> RUN).
REQ-016 SHALL have latency: Start accepted at edge T -> RUN for cycles T+1..T+NBYTES -> Done high in cycle T+NBYTES+1.
REQ-017 SHALL hold Result, Cout, Overflow stable from Done until the next accepted Start; they are undefined-but-stable (partial) during RUN.
REQ-018 SHALL compute Overflow = (A msb == B' msb) && (Result msb != A msb), where B' is B after optional inversion.
REQ-019 SHALL wrap modulo 2^(8*NBYTES); the carry beyond the MSB appears only on Cout.
REQ-020 SHALL ignore Start while in RUN, with no queuing and no effect on the current operation.
REQ-021 SHALL not sample input changes on OpA/OpB/Cin/Sub after the accept cycle.

Reset
REQ-022 SHALL, on rst_n low, immediately set state IDLE, Busy = 0, Done = 0, Result = 0, Cout = 0, Overflow = 0, index = 0, carry = 0.
REQ-023 SHALL, on reset asserted mid-RUN, abort the operation with no Done pulse.
REQ-024 SHALL make the first Start acceptance possible on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL use macro MULTIBYTE_ADD_SEQ_SUB_EN to compile subtraction in or out.
REQ-026 SHALL keep the Sub port present in both builds.
REQ-027 SHALL, when the macro is defined and Sub = 1 at accept, invert every byte of B, force the initial carry to 1 (ignoring Cin), and set Cout = 1 meaning no borrow.
REQ-028 SHALL, when the macro is defined and Sub = 0, perform addition per REQ-013 with Cin.
REQ-029 SHALL, when the macro is not defined, ignore Sub and perform add only.

Verification (NBYTES = 4)
REQ-030 SHALL cover: A=0x000000FF, B=0x00000001, Cin=0 -> Result 0x00000100, Cout 0, Overflow 0, Done exactly 5 cycles after the accept edge.
REQ-031 SHALL cover: A=0xFFFFFFFF, B=0x00000001 -> Result 0x00000000, Cout 1; A=0x7FFFFFFF, B=1 -> Result 0x80000000, Overflow 1.
REQ-032 SHALL cover (macro defined): Sub=1, A=5, B=7 -> Result 0xFFFFFFFE, Cout 0; Sub=1, A=7, B=5 -> 0x00000002, Cout 1. Without the macro, the same stimulus -> 0x0000000C.
REQ-033 SHALL cover: Start pulsed in RUN with different operands -> first result unchanged, no extra Done; Start held through DONE -> second operation begins with no IDLE cycle.
REQ-034 SHALL cover: rst_n low during the RUN byte-2 cycle -> Busy, Result, Cout 0 immediately, no Done; next Start completes normally.
